cache_arbiter: RTL



---
 rtl/lc3b_types.sv | 30 +++
 rtl/cache_arbiter_control.sv | 72 +++++++
 rtl/cache_arbiter.sv | 100 ++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b types: machine word, L1 line, and the arbiter grant encoding.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] l1_cache_line;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } arb_grant_t;

    // Winner of an IDLE-cycle arbitration. A lone requester always wins; on a
    // conflict FAIR alternates away from the previous winner, otherwise D wins.
    function automatic arb_grant_t pick_grant(input logic       i_req,
                                              input logic       d_req,
                                              input logic       fair,
                                              input arb_grant_t last);
        if (i_req && d_req) begin
            if (fair) begin
                return (last == GRANT_I) ? GRANT_D : GRANT_I;
            end
            return GRANT_D;
        end
        if (d_req) begin
            return GRANT_D;
        end
        return GRANT_I;
    endfunction

endpackage

// File: rtl/cache_arbiter_control.sv
// Arbitration FSM: picks a side in IDLE, tracks the serve phase and forces a
// one-cycle RELEASE so the L1's stale request in its response cycle is dropped.
module cache_arbiter_control
    import lc3b_types::*;
#(
    parameter bit FAIR = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_req,
    input  logic       d_req,
    input  logic       mem_resp,
    output arb_grant_t grant,
    output logic       latch_en,
    output logic       serve_i,
    output logic       serve_d,
    output logic       perf_conflict
);

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D,
        RELEASE
    } state_t;

    state_t     state_q, state_d;
    arb_grant_t last_grant_q, last_grant_d;

    // State and fairness history registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_I;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Next-state, grant selection and per-state strobes.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        grant         = pick_grant(i_req, d_req, FAIR, last_grant_q);
        latch_en      = 1'b0;
        serve_i       = 1'b0;
        serve_d       = 1'b0;
        perf_conflict = 1'b0;
        unique case (state_q)
            IDLE: begin
                perf_conflict = i_req & d_req;
                if (i_req || d_req) begin
                    latch_en     = 1'b1;
                    last_grant_d = grant;
                    state_d      = (grant == GRANT_D) ? SERVE_D : SERVE_I;
                end
            end
            SERVE_I: begin
                serve_i = 1'b1;
                if (mem_resp) state_d = RELEASE;
            end
            SERVE_D: begin
                serve_d = 1'b1;
                if (mem_resp) state_d = RELEASE;
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/cache_arbiter.sv
// Serialises I-side and D-side L1 line requests onto one lower memory port.
// The granted request is captured once; later changes on the L1 side are ignored.
module cache_arbiter
    import lc3b_types::*;
#(
    parameter bit FAIR   = 1'b1,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_pmem_read,
    input  logic              i_pmem_write,
    input  logic [ADDR_W-1:0] i_pmem_address,
    input  logic [127:0]      i_pmem_wdata,
    output logic              i_pmem_resp,
    output logic [127:0]      i_pmem_rdata,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [127:0]      d_pmem_wdata,
    output logic              d_pmem_resp,
    output logic [127:0]      d_pmem_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [127:0]      mem_wdata,
    input  logic              mem_resp,
    input  logic [127:0]      mem_rdata,
    output logic              perf_conflict
);

    arb_grant_t        grant;
    logic              latch_en, serve_i, serve_d, serving;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [127:0]      wdata_q, wdata_d;
    logic              rd_q, rd_d, wr_q, wr_d;

    cache_arbiter_control #(.FAIR(FAIR)) u_control (
        .clk           (clk),
        .reset         (reset),
        .i_req         (i_pmem_read | i_pmem_write),
        .d_req         (d_pmem_read | d_pmem_write),
        .mem_resp      (mem_resp),
        .grant         (grant),
        .latch_en      (latch_en),
        .serve_i       (serve_i),
        .serve_d       (serve_d),
        .perf_conflict (perf_conflict)
    );

    // Capture the winner's request at grant; a write beats a simultaneous read.
    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        if (latch_en) begin
            if (grant == GRANT_D) begin
                addr_d  = d_pmem_address;
                wdata_d = d_pmem_wdata;
                wr_d    = d_pmem_write;
                rd_d    = d_pmem_read & ~d_pmem_write;
            end else begin
                addr_d  = i_pmem_address;
                wdata_d = i_pmem_wdata;
                wr_d    = i_pmem_write;
                rd_d    = i_pmem_read & ~i_pmem_write;
            end
        end
    end

    // Latched request registers; cleared on reset so the lower port goes quiet at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    // The lower request is only live while serving; RELEASE and IDLE keep it low.
    assign serving     = serve_i | serve_d;
    assign mem_read    = serving & rd_q;
    assign mem_write   = serving & wr_q;
    assign mem_address = addr_q;
    assign mem_wdata   = wdata_q;

    // Completion goes straight through to the granted side only.
    assign i_pmem_resp  = serve_i & mem_resp;
    assign d_pmem_resp  = serve_d & mem_resp;
    assign i_pmem_rdata = serve_i ? mem_rdata : '0;
    assign d_pmem_rdata = serve_d ? mem_rdata : '0;

endmodule
